// File: rtl/rng_pkg.sv
// rng_pkg: shared definitions for the random-draw unit.
//   state_e       draw controller states (IDLE, DRAW)
//   DEFAULT_TAPS  feedback tap mask of the default 16-bit LFSR
//   DEFAULT_SEED  reset value of the default 16-bit LFSR
package rng_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR with parallel load.
//   clk       system clock, rising edge
//   rst       synchronous reset, active-low; q returns to SEED
//   en        shift enable
//   load      load load_val (has priority over en)
//   load_val  value to load; zero is replaced by 1 so the LFSR never locks up
//   q         current LFSR state
module lfsr_core #(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = rng_pkg::DEFAULT_TAPS,
  parameter logic [LFSR_W-1:0] SEED   = rng_pkg::DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == '0) ? LFSR_W'(1) : load_val;
    end else if (en) begin
      q_d = {q_q[LFSR_W-2:0], ^(q_q & TAPS)};
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) q_q <= SEED;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rng_draw.sv
// rng_draw: random draw unit. A free-running LFSR feeds a draw controller
// that returns one value in 0..RANGE-1 per update request using rejection
// sampling; after MAX_TRIES rejects the previous value plus one (wrapping)
// is used instead.
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   start      LFSR free-run enable
//   update     draw request (ignored while busy)
//   seed_load  load seed_in into the LFSR
//   seed_in    seed value; zero is replaced by 1
//   rngout     held random value
//   valid      high once the first draw has completed
//   done       one-cycle pulse when rngout is written
//   busy       high while drawing
//   fallback   last draw used the fallback value
// Build option: define RNG_NOREPEAT_EN to reject a candidate equal to the
// current rngout, so successive draws never repeat.
module rng_draw
  import rng_pkg::*;
#(
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = DEFAULT_TAPS,
  parameter int unsigned       OUT_W     = 5,
  parameter int unsigned       RANGE     = 26,
  parameter int unsigned       MAX_TRIES = 8,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              update,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [OUT_W-1:0]  rngout,
  output logic              valid,
  output logic              done,
  output logic              busy,
  output logic              fallback
);

  localparam int unsigned          TRIES_W  = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0]   LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [OUT_W:0]       RANGE_X  = (OUT_W + 1)'(RANGE);
  localparam logic [OUT_W-1:0]     LAST_VAL = OUT_W'(RANGE - 1);

  if (RANGE > (1 << OUT_W)) begin : g_bad_range
    $error("rng_draw: RANGE exceeds 2**OUT_W");
  end
  if (OUT_W > LFSR_W) begin : g_bad_width
    $error("rng_draw: OUT_W exceeds LFSR_W");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("rng_draw: SEED must be nonzero");
  end

  state_e             state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0]   rngout_q, rngout_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               fallback_q, fallback_d;

  logic [LFSR_W-1:0]  lfsr_q;
  logic [OUT_W-1:0]   candidate;
  logic               accept;

  // The LFSR also steps while drawing, so each retry sees a fresh candidate
  // even when start is low.
  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (start || (state_q == DRAW)),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr_q)
  );

  assign candidate = lfsr_q[LFSR_W-1 -: OUT_W];

  if (OUT_W < LFSR_W) begin : g_low_bits
    logic lfsr_low_unused;
    assign lfsr_low_unused = ^lfsr_q[LFSR_W-OUT_W-1:0];
  end

`ifdef RNG_NOREPEAT_EN
  assign accept = ({1'b0, candidate} < RANGE_X) &&
                  !(valid_q && (candidate == rngout_q));
`else
  assign accept = ({1'b0, candidate} < RANGE_X);
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tries_d    = tries_q;
    rngout_d   = rngout_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    fallback_d = fallback_q;
    case (state_q)
      IDLE: begin
        if (update) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (accept) begin
          rngout_d   = candidate;
          done_d     = 1'b1;
          fallback_d = 1'b0;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else if (tries_q == LAST_TRY) begin
          // Step from the held value: never repeats and stays in range.
          rngout_d   = (rngout_q == LAST_VAL) ? '0 : rngout_q + 1'b1;
          done_d     = 1'b1;
          fallback_d = 1'b1;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: only control and output registers exist here and all of them are
  // reset; a reset mid-draw simply drops the draw without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      tries_q    <= '0;
      rngout_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      rngout_q   <= rngout_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      fallback_q <= fallback_d;
    end
  end

  assign rngout   = rngout_q;
  assign valid    = valid_q;
  assign done     = done_q;
  assign busy     = (state_q == DRAW);
  assign fallback = fallback_q;

endmodule

// File: tb/tb_rng_draw.sv
// tb_rng_draw: directed bench for rng_draw. Instance dut uses the default
// parameters; instance dut_f uses MAX_TRIES=2 for the fallback path.
// Expected values follow RNG_NOREPEAT_EN when it is defined for the build.
module tb_rng_draw;

  logic        clk = 1'b0;
  logic        rst;

  logic        start, update, seed_load;
  logic [15:0] seed_in;
  logic [4:0]  rngout;
  logic        valid, done, busy, fallback;

  logic        start_f, update_f, seed_load_f;
  logic [15:0] seed_in_f;
  logic [4:0]  rngout_f;
  logic        valid_f, done_f, busy_f, fallback_f;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rng_draw dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .update    (update),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .rngout    (rngout),
    .valid     (valid),
    .done      (done),
    .busy      (busy),
    .fallback  (fallback)
  );

  rng_draw #(.MAX_TRIES(2)) dut_f (
    .clk       (clk),
    .rst       (rst),
    .start     (start_f),
    .update    (update_f),
    .seed_load (seed_load_f),
    .seed_in   (seed_in_f),
    .rngout    (rngout_f),
    .valid     (valid_f),
    .done      (done_f),
    .busy      (busy_f),
    .fallback  (fallback_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a seed together with an update request, then watch the chosen
  // instance for 20 cycles. done_at is the sample index (0 = the cycle after
  // the request edge) of the first done pulse, or -1 if none was seen.
  task automatic run_draw(input bit sel, input logic [15:0] seed,
                          output int busy_cnt, output int done_cnt,
                          output int done_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    if (!sel) begin
      seed_in = seed; seed_load = 1'b1; update = 1'b1;
    end else begin
      seed_in_f = seed; seed_load_f = 1'b1; update_f = 1'b1;
    end
    tick();
    seed_load = 1'b0; update = 1'b0;
    seed_load_f = 1'b0; update_f = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (sel ? busy_f : busy) busy_cnt++;
      if (sel ? done_f : done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (rngout !== 5'd0) begin failures++; $display("FAIL reset_rngout got=%0d exp=0", rngout); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fallback !== 1'b0) begin failures++; $display("FAIL reset_fallback got=%b exp=0", fallback); end
    checks++; if (dut.lfsr_q !== 16'hACE1) begin failures++; $display("FAIL reset_lfsr got=%h exp=ace1", dut.lfsr_q); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_rejection();
    int b, d, at;
    run_draw(1'b0, 16'hF800, b, d, at);
    checks++; if (b !== 4) begin failures++; $display("FAIL rej_busy_cycles got=%0d exp=4", b); end
    checks++; if (d !== 1) begin failures++; $display("FAIL rej_done_count got=%0d exp=1", d); end
    checks++; if (at !== 4) begin failures++; $display("FAIL rej_latency got=%0d exp=4", at); end
    checks++; if (rngout !== 5'd24) begin failures++; $display("FAIL rej_rngout got=%0d exp=24", rngout); end
    checks++; if (fallback !== 1'b0) begin failures++; $display("FAIL rej_fallback got=%b exp=0", fallback); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL rej_valid got=%b exp=1", valid); end
  endtask

  task automatic test_norepeat();
    int b, d, at;
`ifdef RNG_NOREPEAT_EN
    localparam logic [4:0] EXP_VAL = 5'd16;
    localparam int         EXP_AT  = 2;
`else
    localparam logic [4:0] EXP_VAL = 5'd24;
    localparam int         EXP_AT  = 1;
`endif
    run_draw(1'b0, 16'hC006, b, d, at);
    checks++; if (rngout !== EXP_VAL) begin failures++; $display("FAIL norep_rngout got=%0d exp=%0d", rngout, EXP_VAL); end
    checks++; if (at !== EXP_AT) begin failures++; $display("FAIL norep_latency got=%0d exp=%0d", at, EXP_AT); end
    checks++; if (d !== 1) begin failures++; $display("FAIL norep_done_count got=%0d exp=1", d); end
  endtask

  task automatic test_fallback();
    int b, d, at;
    run_draw(1'b1, 16'hF800, b, d, at);
    checks++; if (rngout_f !== 5'd1) begin failures++; $display("FAIL fb_rngout got=%0d exp=1", rngout_f); end
    checks++; if (fallback_f !== 1'b1) begin failures++; $display("FAIL fb_flag got=%b exp=1", fallback_f); end
    checks++; if (at !== 2) begin failures++; $display("FAIL fb_latency got=%0d exp=2", at); end
    checks++; if (valid_f !== 1'b1) begin failures++; $display("FAIL fb_valid got=%b exp=1", valid_f); end
    run_draw(1'b1, 16'hC800, b, d, at);
    checks++; if (rngout_f !== 5'd25) begin failures++; $display("FAIL fb_set25 got=%0d exp=25", rngout_f); end
    checks++; if (fallback_f !== 1'b0) begin failures++; $display("FAIL fb_flag_clear got=%b exp=0", fallback_f); end
    run_draw(1'b1, 16'hF800, b, d, at);
    checks++; if (rngout_f !== 5'd0) begin failures++; $display("FAIL fb_wrap got=%0d exp=0", rngout_f); end
    checks++; if (fallback_f !== 1'b1) begin failures++; $display("FAIL fb_wrap_flag got=%b exp=1", fallback_f); end
  endtask

  task automatic test_back_to_back();
    int dcnt = 0;
    seed_in = 16'hF800; seed_load = 1'b1; update = 1'b1;
    tick();
    seed_load = 1'b0; update = 1'b0;
    for (int j = 0; j < 12; j++) begin
      update = (j == 1 || j == 2);
      if (done) dcnt++;
      tick();
    end
    update = 1'b0;
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", dcnt); end
    checks++; if (rngout !== 5'd24) begin failures++; $display("FAIL b2b_rngout got=%0d exp=24", rngout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_seed_start();
    seed_in = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    checks++; if (dut.lfsr_q !== 16'h0001) begin failures++; $display("FAIL zero_seed got=%h exp=0001", dut.lfsr_q); end
    seed_in = 16'hF800; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (dut.lfsr_q !== 16'hF001) begin failures++; $display("FAIL start_step got=%h exp=f001", dut.lfsr_q); end
    tick();
    checks++; if (dut.lfsr_q !== 16'hF001) begin failures++; $display("FAIL start_hold got=%h exp=f001", dut.lfsr_q); end
  endtask

  task automatic test_mid_reset();
    int dcnt = 0;
    seed_in = 16'hF800; seed_load = 1'b1; update = 1'b1;
    tick();
    seed_load = 1'b0; update = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (rngout !== 5'd0) begin failures++; $display("FAIL midrst_rngout got=%0d exp=0", rngout); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid); end
    for (int j = 0; j < 6; j++) begin
      if (done) dcnt++;
      tick();
    end
    checks++; if (dcnt !== 0) begin failures++; $display("FAIL midrst_done_count got=%0d exp=0", dcnt); end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; update = 1'b0; seed_load = 1'b0; seed_in = '0;
    start_f = 1'b0; update_f = 1'b0; seed_load_f = 1'b0; seed_in_f = '0;
    #2;
    test_reset();
    test_rejection();
    test_norepeat();
    test_fallback();
    test_back_to_back();
    test_seed_start();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rng_draw.md
# rng_draw

Parametrised random-draw unit for the trainer datapath. It is the successor of the fixed 4-bit random-number register. A free-running Fibonacci LFSR of configurable width and taps feeds a draw controller. The controller returns one value in 0..RANGE-1 per update request, using rejection sampling with a bounded retry count, and holds that value until the next request. It supplies symbol and letter indices to the lesson and quiz logic.

## Interface
- LFSR_W, 16, LFSR width in bits.
- TAPS, 16'hB400, feedback tap mask (bit i set means lfsr[i] is XORed into feedback).
- OUT_W, 5, output width.
- RANGE, 26, number of legal values; 2 ≤ RANGE ≤ 2^OUT_W.
- MAX_TRIES, 8, maximum DRAW cycles before fallback; ≥ 1.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  LFSR free-run enable.
- update  in  1  draw request.
- seed_load  in  1  load seed_in into the LFSR.
- seed_in  in  LFSR_W  seed value; zero is replaced by 1.
- rngout  out  OUT_W  held random value.
- valid  out  1  high once the first draw has completed; stays high.
- done  out  1  one-cycle pulse when rngout is written.
- busy  out  1  high while in DRAW.
- fallback  out  1  high if the last draw used the fallback value.

## Operation
- LFSR update, per cycle:
  - seed_load=1: lfsr ← (seed_in==0 ? 1 : seed_in). seed_load has priority over shifting.
  - else, if start=1 or state==DRAW: lfsr ← {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
  - else: lfsr holds.
- Candidate is lfsr[LFSR_W-1 -: OUT_W], taken from the current (pre-shift) LFSR value.
- FSM states: IDLE, DRAW.
  - IDLE, update=1: go to DRAW, tries ← 0. IDLE with update=0: stay.
  - DRAW, candidate accepted: rngout ← candidate, done ← 1, fallback ← 0, valid ← 1, go to IDLE.
  - DRAW, candidate rejected and tries==MAX_TRIES-1: rngout ← (rngout==RANGE-1 ? 0 : rngout+1), done ← 1, fallback ← 1, valid ← 1, go to IDLE.
  - DRAW, otherwise: tries ← tries+1, stay.
- Accept rule: candidate < RANGE, and the no-repeat condition when that feature is compiled in (see Configuration).
- update while in DRAW is ignored; requests are not queued.
- seed_load during DRAW reloads the LFSR; the draw continues from the new value.
- tries is $clog2(MAX_TRIES+1) bits wide. Comparisons are unsigned.

## Timing
- Reset (rst=0 at edge): lfsr=SEED, state=IDLE, rngout=0, valid=0, done=0, busy=0, fallback=0, tries=0. Reset mid-DRAW aborts the draw; no done pulse is produced.
- busy = (state==DRAW), decoded from the state register.
- Latency: if update is sampled at edge n, rngout and done update at edge n+1+k, where k is the number of rejected candidates. Minimum 2 cycles; maximum MAX_TRIES+1.
- done is high for exactly one cycle per draw.
- rngout is stable between done pulses.

## Configuration
- RNG_NOREPEAT_EN defined:
  - Once valid=1, a candidate equal to the current rngout is rejected.
  - Successive draws never repeat, including fallback draws.
- RNG_NOREPEAT_EN undefined:
  - The equality check is removed.
  - Repeats are allowed; only candidate < RANGE is checked.

## Structure
- rng_pkg holds: the state enum (IDLE, DRAW), the default tap constant 16'hB400, and the default seed.
- One sub-module, lfsr_core (params LFSR_W, TAPS, SEED; ports clk, rst, en, load, load_val, q). It contains the shift/load logic and the zero-seed guard.
- rng_draw contains the FSM, the accept/fallback logic and the output registers.
- Elaboration-time checks: RANGE ≤ 2^OUT_W, OUT_W ≤ LFSR_W, SEED ≠ 0.

## Test plan
- Reset value: hold rst=0 for 3 cycles -> rngout=0, valid=0, done=0, busy=0, lfsr=16'hACE1.
- Rejection sequence, defaults: seed_load=1 with seed_in=16'hF800 and update=1 in the same cycle. The LFSR steps F800→F001→E003→C006, giving candidates 31, 30, 28 (rejected) then 24 (accepted) -> busy for 4 cycles, done once, rngout=24, fallback=0.
- No-repeat, macro defined: after the draw above (rngout=24), seed_load 16'hC006 together with update -> 24 rejected, LFSR steps to 800D -> rngout=16. With the macro undefined -> rngout=24.
- Fallback: MAX_TRIES=2, rngout=0, seed_load 16'hF800 with update -> two rejects (31, 30) -> rngout=1, fallback=1. Repeat the same stimulus with rngout=25 -> rngout=0 (wrap).
- Ignored request and zero seed: pulse update twice while busy -> exactly one done. seed_load with seed_in=0 -> lfsr=16'h0001.
- Mid-draw reset: rst=0 during DRAW -> next cycle busy=0, no done, rngout=0, valid=0.
